// File: rtl/matrix_pkg.sv
// Opcodes, instruction field layout and sequencer states shared by the matrix sequencer.
package matrix_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 4;
  localparam int ADDR_LSB = 4;
  localparam int VAL_LSB  = 16;

  typedef enum logic [2:0] {
    IDLE, DECODE, LOAD_OPS, ALU_RUN, DUMP, MEM_OP, DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/matrix_sequencer_mem_xfer_ctrl.sv
// Memory handshake, word counter and stall watchdog. Start held until mem_done, then one idle gap cycle;
// stalls on mem_start/alu_start are counted and flagged at TIMEOUT (0 disables).
module mem_xfer_ctrl #(
  parameter int WORDS   = 13,
  parameter int TIMEOUT = 1023,
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active,
  input  logic              mem_done,
  input  logic              alu_wait,
  output logic              mem_start,
  output logic [WORD_W-1:0] word,
  output logic              xfer_step,
  output logic              xfer_last,
  output logic              timeout
);
  logic            gap;
  logic            last_q;
  logic            stall;
  logic            word_end;
  logic [WD_W-1:0] wd_cnt;

  assign mem_start = active && !gap;
  assign stall     = (mem_start && !mem_done) || alu_wait;
  assign word_end  = (word == WORD_W'(WORDS - 1));
  assign xfer_step = gap;
  assign xfer_last = gap && last_q;
  assign timeout   = (TIMEOUT != 0) && stall && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      gap    <= 1'b0;
      last_q <= 1'b0;
      word   <= '0;
      wd_cnt <= '0;
    end else begin
      wd_cnt <= stall ? wd_cnt + 1'b1 : '0;
      if (!active) begin
        gap    <= 1'b0;
        last_q <= 1'b0;
        word   <= '0;
      end else if (mem_start && mem_done) begin
        // the gap cycle already presents the next word so the FSM can act on xfer_last
        gap    <= 1'b1;
        last_q <= word_end;
        word   <= word_end ? '0 : word + 1'b1;
      end else begin
        gap <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/matrix_sequencer.sv
// Instruction sequencer: single LOAD/STORE transfers, or operand streaming, ALU run and result dump.
// One instruction in flight; instr_ready only in IDLE; memory/ALU stalls bounded by the watchdog.
module matrix_sequencer
  import matrix_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int MAT_ELEMS      = 25,
  parameter int ELEMS_PER_WORD = 2,
  parameter int NUM_OPERANDS   = 2,
  parameter int BUF_STRIDE     = 13,
  parameter int TIMEOUT        = 1023
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              instr_valid,
  input  logic [31:0]                       instruction,
  output logic                              instr_ready,
  output logic [3:0]                        op_code,
  output logic                              alu_start,
  input  logic                              alu_done,
  output logic                              alu_dumping,
  output logic                              mem_start,
  output logic                              mem_write_enabled,
  output logic [ADDR_W-1:0]                 mem_address,
  output logic [DATA_W-1:0]                 mem_data_in,
  input  logic                              mem_done,
  output logic [$clog2(NUM_OPERANDS+1)-1:0] buffer_id,
  output logic [$clog2(MAT_ELEMS)-1:0]      buffer_index,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);
  localparam int WORDS  = ceil_div(MAT_ELEMS, ELEMS_PER_WORD);
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BID_W  = $clog2(NUM_OPERANDS + 1);
  localparam int IDX_W  = $clog2(MAT_ELEMS);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   buf_addr;
  logic [WORD_W-1:0]   word;
  logic [3:0]          instr_op;
  logic                accept, last_buf, alu_gap, alu_wait, xfer_active;
  logic                xfer_step, xfer_last, timeout;
  logic                instr_unused;

  assign instr_op     = instruction[OPC_LSB +: OPC_W];
  assign instr_unused = ^instruction;
  assign accept       = (state == IDLE) && instr_valid && (instr_op != OP_NOP);
  assign last_buf     = (buffer_id == BID_W'(NUM_OPERANDS - 1));
  assign buf_addr     = ADDR_W'(int'(buffer_id) * BUF_STRIDE + int'(word));
  assign buffer_index = IDX_W'(int'(word) * ELEMS_PER_WORD);
  assign xfer_active  = (state == MEM_OP) || (state == LOAD_OPS) || (state == DUMP);
  assign alu_start    = (state == ALU_RUN) && !alu_gap;
  assign alu_wait     = alu_start && !alu_done;

  mem_xfer_ctrl #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) u_xfer (
    .clock     (clock),
    .reset     (reset),
    .active    (xfer_active),
    .mem_done  (mem_done),
    .alu_wait  (alu_wait),
    .mem_start (mem_start),
    .word      (word),
    .xfer_step (xfer_step),
    .xfer_last (xfer_last),
    .timeout   (timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_code     <= '0;
      addr_q      <= '0;
      mem_data_in <= '0;
      buffer_id   <= '0;
      alu_gap     <= 1'b0;
      error       <= 1'b0;
    end else begin
      state   <= state_nxt;
      alu_gap <= alu_start && alu_done;
      if (accept) begin
        op_code     <= instr_op;
        addr_q      <= instruction[ADDR_LSB +: ADDR_W];
        mem_data_in <= instruction[VAL_LSB +: DATA_W];
        error       <= 1'b0;
      end
      case (state)
        DECODE:   buffer_id <= '0;
        LOAD_OPS: if (xfer_last && !last_buf) buffer_id <= buffer_id + 1'b1;
        ALU_RUN:  if (alu_gap) buffer_id <= BID_W'(NUM_OPERANDS);
        DONE:     buffer_id <= '0;
        default:  ;
      endcase
      if (timeout) begin
        error     <= 1'b1;
        buffer_id <= '0;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    instr_ready       = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    alu_dumping       = 1'b0;
    mem_write_enabled = 1'b0;
    mem_address       = '0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (accept) state_nxt = DECODE;
      end
      DECODE: state_nxt = (op_code == OP_LOAD || op_code == OP_STORE) ? MEM_OP : LOAD_OPS;
      MEM_OP: begin
        mem_address       = addr_q;
        mem_write_enabled = (op_code == OP_STORE);
        if (xfer_step) state_nxt = DONE;
      end
      LOAD_OPS: begin
        mem_address = buf_addr;
        if (xfer_last && last_buf) state_nxt = ALU_RUN;
      end
      ALU_RUN: if (alu_gap) state_nxt = DUMP;
      DUMP: begin
        alu_dumping       = 1'b1;
        mem_write_enabled = 1'b1;
        mem_address       = buf_addr;
        if (xfer_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // an ALU completion in the same cycle keeps the stall count from expiring
    if (timeout) state_nxt = IDLE;
  end
endmodule
